// File: rtl/parser_seg_bank_ctrl_pkg.sv
// parser_seg_bank_ctrl_pkg: shared widths, bank states and read-FSM states for the segment bank controller
package parser_seg_bank_ctrl_pkg;
  localparam int C_AXIS_DATA_WIDTH  = 256;
  localparam int C_AXIS_TUSER_WIDTH = 128;
  localparam int C_VLANID_WIDTH     = 12;
  localparam int C_NUM_SEGS         = 8;
  localparam int SEG_IDX_W          = 3;
  localparam int BANK_W             = 1;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_BUSY    = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    RD_IDLE      = 2'd0,
    RD_READ      = 2'd1,
    RD_WAIT_DONE = 2'd2
  } rd_state_t;

  function automatic logic bank_writable(bank_state_t s);
    return s == BANK_FREE || s == BANK_FILLING;
  endfunction
endpackage

// File: rtl/parser_seg_bank_ctrl_if.sv
// parser_seg_bank_ctrl_if: collector, RAM and extractor signals of the segment bank controller
interface parser_seg_bank_ctrl_if;
  import parser_seg_bank_ctrl_pkg::*;
  logic [C_AXIS_DATA_WIDTH-1:0]  i_seg_tdata;
  logic                          i_seg_wea;
  logic [SEG_IDX_W-1:0]          i_seg_addra;
  logic                          i_seg_wait_end;
  logic [C_AXIS_TUSER_WIDTH-1:0] i_tuser_1st;
  logic [C_VLANID_WIDTH-1:0]     i_vlan;
  logic                          i_vlan_valid;
  logic                          o_wr_ready;
  logic                          o_ram_wea;
  logic [BANK_W+SEG_IDX_W-1:0]   o_ram_addra;
  logic [C_AXIS_DATA_WIDTH-1:0]  o_ram_dina;
  logic                          o_ram_enb;
  logic [BANK_W+SEG_IDX_W-1:0]   o_ram_addrb;
  logic                          o_rd_sof;
  logic                          o_rd_eof;
  logic [C_AXIS_TUSER_WIDTH-1:0] o_rd_tuser;
  logic [C_VLANID_WIDTH-1:0]     o_rd_vlan;
  logic                          i_rd_ready;
  logic                          i_pkt_done;
  logic                          o_overflow;

  modport slave (
    input  i_seg_tdata, i_seg_wea, i_seg_addra, i_seg_wait_end, i_tuser_1st, i_vlan, i_vlan_valid,
           i_rd_ready, i_pkt_done,
    output o_wr_ready, o_ram_wea, o_ram_addra, o_ram_dina, o_ram_enb, o_ram_addrb, o_rd_sof,
           o_rd_eof, o_rd_tuser, o_rd_vlan, o_overflow
  );

  modport master (
    output i_seg_tdata, i_seg_wea, i_seg_addra, i_seg_wait_end, i_tuser_1st, i_vlan, i_vlan_valid,
           i_rd_ready, i_pkt_done,
    input  o_wr_ready, o_ram_wea, o_ram_addra, o_ram_dina, o_ram_enb, o_ram_addrb, o_rd_sof,
           o_rd_eof, o_rd_tuser, o_rd_vlan, o_overflow
  );
endinterface

// File: rtl/parser_seg_read_seq.sv
// parser_seg_read_seq: IDLE/READ/WAIT_DONE sequencer issuing the 8-segment read-out of a full bank
module parser_seg_read_seq
  import parser_seg_bank_ctrl_pkg::*;
(
  input  logic                        axis_clk,
  input  logic                        aresetn,
  input  logic [1:0]                  bank_full,
  input  logic                        rd_ready,
  input  logic                        pkt_done,
  output logic [BANK_W-1:0]           rd_bank,
  output logic                        start,
  output logic                        done,
  output logic                        enb,
  output logic [BANK_W+SEG_IDX_W-1:0] addrb,
  output logic                        sof,
  output logic                        eof
);
  rd_state_t            state, state_nxt;
  logic [SEG_IDX_W-1:0] rd_idx, idx_nxt;
  logic [BANK_W-1:0]    bank_nxt;

  // state, segment index and bank pointer registers
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      state   <= RD_IDLE;
      rd_idx  <= '0;
      rd_bank <= '0;
    end else begin
      state   <= state_nxt;
      rd_idx  <= idx_nxt;
      rd_bank <= bank_nxt;
    end
  end

  // next state: start only on an already-registered FULL bank, walk 8 segments, then wait for release
  always_comb begin
    state_nxt = state;
    idx_nxt   = rd_idx;
    bank_nxt  = rd_bank;
    start     = 1'b0;
    done      = 1'b0;
    case (state)
      RD_IDLE: if (bank_full[rd_bank] && rd_ready) begin
        start     = 1'b1;
        idx_nxt   = '0;
        state_nxt = RD_READ;
      end
      RD_READ: begin
        idx_nxt = rd_idx + 1'b1;
        if (rd_idx == SEG_IDX_W'(C_NUM_SEGS - 1)) state_nxt = RD_WAIT_DONE;
      end
      RD_WAIT_DONE: if (pkt_done) begin
        done      = 1'b1;
        bank_nxt  = ~rd_bank;
        state_nxt = RD_IDLE;
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  assign enb   = state == RD_READ;
  assign addrb = {rd_bank, rd_idx};
  assign sof   = enb && rd_idx == '0;
  assign eof   = enb && rd_idx == SEG_IDX_W'(C_NUM_SEGS - 1);
endmodule

// File: rtl/parser_seg_bank_ctrl.sv
// parser_seg_bank_ctrl: ping-pong bank steering, metadata latching and read sequencing for the parser segment RAM
module parser_seg_bank_ctrl
  import parser_seg_bank_ctrl_pkg::*;
(
  input logic                   axis_clk,
  input logic                   aresetn,
  parser_seg_bank_ctrl_if.slave bus
);
  bank_state_t                   bank_q [2];
  bank_state_t                   bank_nxt [2];
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_q [2];
  logic [C_VLANID_WIDTH-1:0]     vlan_q [2];
  logic [BANK_W-1:0]             wr_bank, wr_bank_nxt, rd_bank;
  logic                          wr_ok, wr_acc, rd_start, rd_done;
  logic [1:0]                    bank_full;
  logic                          ram_wea, wr_ready, overflow;
  logic [BANK_W+SEG_IDX_W-1:0]   ram_addra, ram_addrb;
  logic [C_AXIS_DATA_WIDTH-1:0]  ram_dina;
  logic [C_AXIS_TUSER_WIDTH-1:0] rd_tuser;
  logic [C_VLANID_WIDTH-1:0]     rd_vlan;
  logic                          ram_enb, rd_sof, rd_eof;

  assign wr_ok     = bank_writable(bank_q[wr_bank]);
  assign wr_acc    = bus.i_seg_wea && wr_ok;
  assign bank_full = {bank_q[1] == BANK_FULL, bank_q[0] == BANK_FULL};

  parser_seg_read_seq u_read_seq (
    .axis_clk  (axis_clk),
    .aresetn   (aresetn),
    .bank_full (bank_full),
    .rd_ready  (bus.i_rd_ready),
    .pkt_done  (bus.i_pkt_done),
    .rd_bank   (rd_bank),
    .start     (rd_start),
    .done      (rd_done),
    .enb       (ram_enb),
    .addrb     (ram_addrb),
    .sof       (rd_sof),
    .eof       (rd_eof)
  );

  // bank status next state: write side first, read side touches only the bank it owns
  always_comb begin
    bank_nxt    = bank_q;
    wr_bank_nxt = wr_bank;
    if (wr_acc) bank_nxt[wr_bank] = BANK_FILLING;
    if (wr_ok && bus.i_seg_wait_end) begin
      bank_nxt[wr_bank] = BANK_FULL;
      wr_bank_nxt       = ~wr_bank;
    end
    if (rd_start) bank_nxt[rd_bank] = BANK_BUSY;
    if (rd_done) bank_nxt[rd_bank] = BANK_FREE;
  end

  // registered write port, bank status, per-bank metadata and read-side metadata outputs
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      bank_q    <= '{BANK_FREE, BANK_FREE};
      tuser_q   <= '{default: '0};
      vlan_q    <= '{default: '0};
      wr_bank   <= '0;
      ram_wea   <= 1'b0;
      ram_addra <= '0;
      ram_dina  <= '0;
      wr_ready  <= 1'b1;
      overflow  <= 1'b0;
      rd_tuser  <= '0;
      rd_vlan   <= '0;
    end else begin
      bank_q   <= bank_nxt;
      wr_bank  <= wr_bank_nxt;
      wr_ready <= bank_writable(bank_nxt[wr_bank_nxt]);
      ram_wea  <= wr_acc;
      overflow <= overflow | (bus.i_seg_wea & ~wr_ok);
      if (wr_acc) begin
        ram_addra <= {wr_bank, bus.i_seg_addra};
        ram_dina  <= bus.i_seg_tdata;
      end
      if (wr_acc && bus.i_seg_addra == '0) tuser_q[wr_bank] <= bus.i_tuser_1st;
      if (wr_ok && bus.i_vlan_valid) vlan_q[wr_bank] <= bus.i_vlan;
      if (rd_start) begin
        rd_tuser <= tuser_q[rd_bank];
        rd_vlan  <= vlan_q[rd_bank];
      end
    end
  end

  assign bus.o_wr_ready  = wr_ready;
  assign bus.o_ram_wea   = ram_wea;
  assign bus.o_ram_addra = ram_addra;
  assign bus.o_ram_dina  = ram_dina;
  assign bus.o_ram_enb   = ram_enb;
  assign bus.o_ram_addrb = ram_addrb;
  assign bus.o_rd_sof    = rd_sof;
  assign bus.o_rd_eof    = rd_eof;
  assign bus.o_rd_tuser  = rd_tuser;
  assign bus.o_rd_vlan   = rd_vlan;
  assign bus.o_overflow  = overflow;
endmodule

// File: doc/parser_seg_bank_ctrl.md
Name: parser_seg_bank_ctrl

Overview:
- Ping-pong controller for the parser segment RAM: two banks of 8 x 256b segments, addressed as {bank, seg_idx}.
- Sits between the segment-collection stage and the header-extraction stage.
- Steers each 8-segment packet header into a free bank and latches its tuser and VLAN.
- Sequences the 8-cycle read-out of full banks, then recycles each bank when the consumer signals done.
- Back-pressures the collection stage when no bank is free.

Parameters:
C_AXIS_DATA_WIDTH, 256, segment width
C_AXIS_TUSER_WIDTH, 128, first-segment tuser width
C_VLANID_WIDTH, 12, VLAN id width
C_NUM_SEGS, 8, segments per bank (fixed at 8; seg index 3 bits)

Ports:
axis_clk  in  1  clock
aresetn  in  1  synchronous active-low reset
i_seg_tdata  in  256  segment data from collector
i_seg_wea  in  1  segment write strobe
i_seg_addra  in  3  segment index 0..7
i_seg_wait_end  in  1  1-cycle pulse: all 8 segments written
i_tuser_1st  in  128  tuser of current packet
i_vlan  in  12  VLAN id
i_vlan_valid  in  1  VLAN strobe (coincides with seg 0 write)
o_wr_ready  out  1  a free bank is available to the collector
o_ram_wea  out  1  RAM port A write enable
o_ram_addra  out  4  {wr_bank, i_seg_addra}
o_ram_dina  out  256  RAM port A data
o_ram_enb  out  1  RAM port B read enable
o_ram_addrb  out  4  {rd_bank, rd_idx}
o_rd_sof  out  1  high with the seg-0 read
o_rd_eof  out  1  high with the seg-7 read
o_rd_tuser  out  128  tuser of the bank being read
o_rd_vlan  out  12  VLAN of the bank being read
i_rd_ready  in  1  extractor can accept a new packet
i_pkt_done  in  1  1-cycle pulse: extractor finished with current bank
o_overflow  out  1  sticky: write arrived with no free bank

Behaviour:
- Reset (aresetn=0 at a clock edge):
  - Both banks FREE; wr_bank=0, rd_bank=0; read FSM IDLE.
  - All outputs 0, except o_wr_ready=1.
  - Reset mid-read or mid-fill discards all bank contents and state.
- Bank status: FREE, FILLING, FULL, BUSY (one 2-bit state per bank).
- Write side (registered, 1-cycle latency to RAM port A):
  - i_seg_wea with bank[wr_bank] FREE or FILLING: o_ram_wea=1, o_ram_addra={wr_bank,i_seg_addra}, o_ram_dina=i_seg_tdata; bank becomes FILLING.
  - On the seg-0 write, latch i_tuser_1st into that bank's tuser register.
  - On i_vlan_valid, latch i_vlan into that bank's VLAN register.
  - i_seg_wait_end: bank[wr_bank] goes FULL; wr_bank toggles next cycle.
  - i_seg_wea while bank[wr_bank] is FULL or BUSY: the write is dropped, o_ram_wea stays 0, o_overflow sets (cleared only by reset).
- o_wr_ready (registered): 1 iff bank[wr_bank] is FREE or FILLING, evaluated on next-state values.
  - Drops the cycle after wait_end if the other bank is not FREE.
- Read FSM states and transitions:
  - IDLE: if bank[rd_bank]==FULL and i_rd_ready, load o_rd_tuser/o_rd_vlan from rd_bank, set bank BUSY, rd_idx=0, go to READ.
  - READ: for 8 consecutive cycles, o_ram_enb=1, o_ram_addrb={rd_bank,rd_idx}, rd_idx increments. o_rd_sof at idx 0, o_rd_eof at idx 7. After idx 7, go to WAIT_DONE.
  - WAIT_DONE: on i_pkt_done, set bank[rd_bank] FREE, toggle rd_bank, go to IDLE.
  - i_pkt_done received in any other state is ignored.
  - No stalls inside READ: i_rd_ready is sampled only in IDLE.
- RAM read latency is owned by the consumer; this block only issues addresses.
- Simultaneous events:
  - wait_end on one bank and pkt_done on the other in the same cycle: both updates apply, and o_wr_ready reflects the freed bank.
  - wait_end and the IDLE start condition on the same bank in the same cycle: the start is deferred one cycle, because FULL must be registered first.
- Minimum time from wait_end to first o_ram_enb: 2 cycles.
- Throughput: one packet per max(collector time, 8 + extractor time) cycles.

Decomposition:
- Shared parser package holds:
  - bank-state encodings (FREE=0, FILLING=1, FULL=2, BUSY=3);
  - SEG_IDX_W=3, BANK_W=1;
  - the read-FSM state constants.
- One natural sub-module: parser_seg_read_seq, the IDLE/READ/WAIT_DONE FSM plus rd_idx counter, sof/eof generation and rd_bank pointer.
- Bank status, write steering and metadata registers stay in the top.

Test Plan:
- Single packet: write segs 0..7 to bank 0 with vlan=0x123, tuser=0xA5..; wait_end; i_rd_ready=1.
  -> o_ram_enb for 8 cycles with addrb 0..7, sof at 0, eof at 7, o_rd_vlan=0x123; after i_pkt_done, bank 0 is FREE.
- Ping-pong: two back-to-back packets, consumer never done.
  -> second packet lands in addrs 8..15; o_wr_ready=0 after the second wait_end; a third write sets o_overflow and produces no o_ram_wea.
- Release: from the ping-pong state, pulse i_pkt_done.
  -> o_wr_ready returns to 1 next cycle; the second bank's read starts with addrb=8 and carries the second packet's VLAN.
- Simultaneous: wait_end on bank 1 and i_pkt_done on bank 0 in the same cycle.
  -> bank 0 FREE, bank 1 FULL, o_wr_ready=1, read of bank 1 begins 2 cycles later.
- i_rd_ready low: a FULL bank waits in IDLE with no o_ram_enb until i_rd_ready=1, then reading starts on the next cycle.
- Reset at READ idx 4: aresetn=0 for one cycle.
  -> o_ram_enb=0, o_wr_ready=1, o_overflow=0; the next packet writes bank 0 at addr 0.
